wb_arbiter: RTL and testbench

Writeback arbiter feeding the per-thread register files' single shared write port (wr_en / wr_trd / reg_wr / wr_data).
- Merges two result sources:
  - the fixed-latency ALU pipe;
  - variable-latency load returns, buffered in a small load queue (LQ).
- ALU has priority. A starvation counter guarantees load forward progress.
- A thread kill/init squashes all in-flight writes of that thread, so a freshly initialised thread never receives stale results.

---
 rtl/wb_arbiter_pkg.sv | 38 +++
 rtl/wb_arbiter_if.sv | 49 ++++
 rtl/wb_arbiter_lq.sv | 76 +++++++
 rtl/wb_arbiter.sv | 133 +++++++++++++
 tb/tb_wb_arbiter.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for the writeback arbiter slice.
// Contents: thread/register/data widths, default load-queue depth and
// starvation limit, the writeback request record used by the ALU path, the
// load path and the load queue, the arbitration source enum, and a helper
// that says whether a destination register may be written.
package wb_arbiter_pkg;

  localparam int unsigned NUM_TRD        = 8;
  localparam int unsigned TRD_W          = $clog2(NUM_TRD);
  localparam int unsigned REG_W          = 5;
  localparam int unsigned DATA_W         = 32;
  localparam int unsigned LQ_DEPTH_DEF   = 4;
  localparam int unsigned STARVE_MAX_DEF = 7;
  localparam int unsigned CNT_W          = $clog2(LQ_DEPTH_DEF + 1);

  // vld here means "not squashed": it is cleared by a thread kill while the
  // entry still occupies its slot.
  typedef struct packed {
    logic              vld;
    logic [TRD_W-1:0]  trd;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  typedef enum logic [2:0] {
    SRC_NONE,
    SRC_LQ_STARVE,
    SRC_ALU,
    SRC_LQ,
    SRC_BYPASS
  } wb_src_e;

  // Registers 0 and 1 are architecturally fixed and never written.
  function automatic logic rd_writable(input logic [REG_W-1:0] rd);
    return rd > REG_W'(1);
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Bus bundle between the result producers and the writeback arbiter.
// Signals:
//   alu_vld/alu_trd/alu_rd/alu_data  ALU result, alu_stall back-pressure
//   ld_vld/ld_trd/ld_rd/ld_data      load return, ld_rdy handshake
//   kill_vld/kill_trd                thread init/kill
//   wr_en/wr_trd/reg_wr/wr_data      registered regfile write port
//   lq_cnt                           load queue occupancy
// Modports: master = producers/regfile side, slave = arbiter.
interface wb_arbiter_if;
  import wb_arbiter_pkg::*;

  logic              alu_vld;
  logic [TRD_W-1:0]  alu_trd;
  logic [REG_W-1:0]  alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              alu_stall;

  logic              ld_vld;
  logic [TRD_W-1:0]  ld_trd;
  logic [REG_W-1:0]  ld_rd;
  logic [DATA_W-1:0] ld_data;
  logic              ld_rdy;

  logic              kill_vld;
  logic [TRD_W-1:0]  kill_trd;

  logic              wr_en;
  logic [TRD_W-1:0]  wr_trd;
  logic [REG_W-1:0]  reg_wr;
  logic [DATA_W-1:0] wr_data;
  logic [CNT_W-1:0]  lq_cnt;

  modport master (
    output alu_vld, alu_trd, alu_rd, alu_data,
    output ld_vld, ld_trd, ld_rd, ld_data,
    output kill_vld, kill_trd,
    input  alu_stall, ld_rdy,
    input  wr_en, wr_trd, reg_wr, wr_data, lq_cnt
  );

  modport slave (
    input  alu_vld, alu_trd, alu_rd, alu_data,
    input  ld_vld, ld_trd, ld_rd, ld_data,
    input  kill_vld, kill_trd,
    output alu_stall, ld_rdy,
    output wr_en, wr_trd, reg_wr, wr_data, lq_cnt
  );

endinterface

// File: rtl/wb_arbiter_lq.sv
// wb_lq: circular FIFO of writeback requests buffering load returns.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   push, push_req      enqueue at tail (ignored when full)
//   pop                 dequeue head (ignored when empty)
//   kill_vld, kill_trd  clear the valid bit of every entry of kill_trd
//   head                current head entry
//   count, full, empty  occupancy
module wb_lq
  import wb_arbiter_pkg::*;
#(
  parameter  int unsigned DEPTH = LQ_DEPTH_DEF,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  wb_req_t          push_req,
  input  logic             pop,
  input  logic             kill_vld,
  input  logic [TRD_W-1:0] kill_trd,
  output wb_req_t          head,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  wb_req_t          mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];
  assign count   = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[PTR_W'(i)] <= '0;
      end
    end else begin
      // Killed entries keep their slot; only the valid bit drops so the
      // eventual pop still consumes the slot but writes nothing.
      if (kill_vld) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (mem[PTR_W'(i)].trd == kill_trd) begin
            mem[PTR_W'(i)].vld <= 1'b0;
          end
        end
      end
      if (do_push) begin
        mem[wr_ptr] <= push_req;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges ALU results and load returns onto the shared register
// file write port. ALU has priority; loads not written immediately wait in
// the load queue; a starvation counter forces one queue pop after
// STARVE_MAX consecutive ALU wins with loads waiting. Thread kill squashes
// all in-flight writes of that thread.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         wb_arbiter_if.slave (ALU/load inputs, kill, write port,
//               alu_stall, ld_rdy, lq_cnt)
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned LQ_DEPTH   = LQ_DEPTH_DEF,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input logic          clk,
  input logic          rst_n,
  wb_arbiter_if.slave  bus
);

  localparam int unsigned LQ_CW = $clog2(LQ_DEPTH + 1);
  localparam int unsigned SC_W  = $clog2(STARVE_MAX + 1);

  wb_req_t           alu_req;
  wb_req_t           ld_req;
  wb_req_t           lq_head;
  wb_req_t           win;
  wb_src_e           src;
  logic              lq_full;
  logic              lq_empty;
  logic [LQ_CW-1:0]  lq_count;
  logic              lq_push;
  logic              lq_pop;
  logic              ld_acc;
  logic              alu_stall_w;
  logic              wr_en_nxt;
  logic [SC_W-1:0]   starve_cnt;
  logic [SC_W-1:0]   starve_nxt;

  logic              wr_en_q;
  logic [TRD_W-1:0]  wr_trd_q;
  logic [REG_W-1:0]  reg_wr_q;
  logic [DATA_W-1:0] wr_data_q;

  // Incoming results of a thread being killed this cycle are accepted but
  // marked squashed.
  assign alu_req = '{vld:  !(bus.kill_vld && (bus.alu_trd == bus.kill_trd)),
                     trd:  bus.alu_trd,
                     rd:   bus.alu_rd,
                     data: bus.alu_data};
  assign ld_req  = '{vld:  !(bus.kill_vld && (bus.ld_trd == bus.kill_trd)),
                     trd:  bus.ld_trd,
                     rd:   bus.ld_rd,
                     data: bus.ld_data};

  assign alu_stall_w = !lq_empty && (starve_cnt == SC_W'(STARVE_MAX));
  assign ld_acc      = bus.ld_vld && !lq_full;

  always_comb begin
    src        = SRC_NONE;
    win        = '0;
    lq_pop     = 1'b0;
    starve_nxt = '0;
    if (alu_stall_w) begin
      src    = SRC_LQ_STARVE;
      win    = lq_head;
      lq_pop = 1'b1;
    end else if (bus.alu_vld) begin
      src = SRC_ALU;
      win = alu_req;
    end else if (!lq_empty) begin
      src    = SRC_LQ;
      win    = lq_head;
      lq_pop = 1'b1;
    end else if (ld_acc) begin
      src = SRC_BYPASS;
      win = ld_req;
    end

    // Squashed loads never enter the queue.
    lq_push = ld_acc && (src != SRC_BYPASS) && ld_req.vld;

    // Counts ALU wins while loads are waiting, including one pushed now.
    if ((src == SRC_ALU) && (!lq_empty || lq_push)) begin
      starve_nxt = (starve_cnt == SC_W'(STARVE_MAX)) ? starve_cnt
                                                     : starve_cnt + 1'b1;
    end

    wr_en_nxt = (src != SRC_NONE) && win.vld && rd_writable(win.rd) &&
                !(bus.kill_vld && (win.trd == bus.kill_trd));
  end

  wb_lq #(.DEPTH(LQ_DEPTH)) u_lq (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (lq_push),
    .push_req (ld_req),
    .pop      (lq_pop),
    .kill_vld (bus.kill_vld),
    .kill_trd (bus.kill_trd),
    .head     (lq_head),
    .count    (lq_count),
    .full     (lq_full),
    .empty    (lq_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q    <= 1'b0;
      wr_trd_q   <= '0;
      reg_wr_q   <= '0;
      wr_data_q  <= '0;
      starve_cnt <= '0;
    end else begin
      wr_en_q    <= wr_en_nxt;
      starve_cnt <= starve_nxt;
      if (src != SRC_NONE) begin
        wr_trd_q  <= win.trd;
        reg_wr_q  <= win.rd;
        wr_data_q <= win.data;
      end
    end
  end

  assign bus.wr_en     = wr_en_q;
  assign bus.wr_trd    = wr_trd_q;
  assign bus.reg_wr    = reg_wr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.alu_stall = alu_stall_w;
  assign bus.ld_rdy    = !lq_full;
  assign bus.lq_cnt    = CNT_W'(lq_count);

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: reset, bypass, ALU/load conflict, load
// starvation, queue full back-pressure, thread kill, reg 0/1 suppression,
// and reset while the queue holds entries.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  wb_arbiter_if bus ();

  wb_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
  endtask

  task automatic chk_wr(input string tag, input logic en, input logic [2:0] trd,
                        input logic [4:0] rd, input logic [31:0] data);
    chk({tag, ".wr_en"},   32'(bus.wr_en),  32'(en));
    chk({tag, ".wr_trd"},  32'(bus.wr_trd), 32'(trd));
    chk({tag, ".reg_wr"},  32'(bus.reg_wr), 32'(rd));
    chk({tag, ".wr_data"}, bus.wr_data,     data);
  endtask

  task automatic chk_en(input string tag, input logic en);
    chk({tag, ".wr_en"}, 32'(bus.wr_en), 32'(en));
  endtask

  task automatic chk_q(input string tag, input int unsigned cnt, input logic rdy, input logic stall);
    chk({tag, ".lq_cnt"},    32'(bus.lq_cnt),    cnt);
    chk({tag, ".ld_rdy"},    32'(bus.ld_rdy),    32'(rdy));
    chk({tag, ".alu_stall"}, 32'(bus.alu_stall), 32'(stall));
  endtask

  task automatic alu(input logic v, input logic [2:0] trd, input logic [4:0] rd, input logic [31:0] data);
    bus.alu_vld = v; bus.alu_trd = trd; bus.alu_rd = rd; bus.alu_data = data;
  endtask

  task automatic ld(input logic v, input logic [2:0] trd, input logic [4:0] rd, input logic [31:0] data);
    bus.ld_vld = v; bus.ld_trd = trd; bus.ld_rd = rd; bus.ld_data = data;
  endtask

  task automatic kill(input logic v, input logic [2:0] trd);
    bus.kill_vld = v; bus.kill_trd = trd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    alu(0, 0, 0, 0); ld(0, 0, 0, 0); kill(0, 0);
    tick(); tick();
    chk_wr("reset", 0, 0, 0, 0);
    chk_q("reset", 0, 1, 0);
    rst_n = 1'b1;
    tick();
    chk_en("idle", 0);

    // Bypass: empty queue, load goes straight to the write port.
    ld(1, 2, 5, 32'hDEADBEEF);
    tick();
    chk_wr("bypass", 1, 2, 5, 32'hDEADBEEF);
    chk_q("bypass", 0, 1, 0);
    ld(0, 0, 0, 0);
    tick();
    chk_en("bypass_idle", 0);

    // Conflict: ALU first, queued load next cycle.
    alu(1, 1, 7, 32'h11); ld(1, 3, 9, 32'h22);
    tick();
    chk_wr("conflict_alu", 1, 1, 7, 32'h11);
    chk_q("conflict_alu", 1, 1, 0);
    alu(0, 0, 0, 0); ld(0, 0, 0, 0);
    tick();
    chk_wr("conflict_ld", 1, 3, 9, 32'h22);
    chk_q("conflict_ld", 0, 1, 0);

    // Starvation: seven ALU wins, then a forced pop, then the held ALU result.
    for (int i = 0; i < 7; i++) begin
      alu(1, 0, 10, 32'h100 + 32'(i));
      ld(i == 0, 6, 12, 32'h600);
      tick();
      chk_wr("starve_alu", 1, 0, 10, 32'h100 + 32'(i));
      chk_q("starve_alu", 1, 1, i == 6);
    end
    alu(1, 0, 10, 32'h107); ld(0, 0, 0, 0);
    tick();
    chk_wr("starve_pop", 1, 6, 12, 32'h600);
    chk_q("starve_pop", 0, 1, 0);
    tick();
    chk_wr("starve_held", 1, 0, 10, 32'h107);

    // Full: four loads queue behind a busy ALU; a fifth waits for a pop.
    for (int k = 0; k < 4; k++) begin
      alu(1, 1, 2, 32'h200 + 32'(k));
      ld(1, 7, 5'(16 + k), 32'h700 + 32'(k));
      tick();
      chk("full_fill.wr_data", bus.wr_data, 32'h200 + 32'(k));
    end
    chk_q("full", 4, 0, 0);
    alu(1, 1, 2, 32'h204); ld(1, 7, 20, 32'h704);
    tick();
    chk("full_fifth.wr_data", bus.wr_data, 32'h204);
    chk_q("full_fifth", 4, 0, 0);
    alu(0, 0, 0, 0);
    tick();
    chk_wr("full_pop0", 1, 7, 16, 32'h700);
    chk_q("full_pop0", 3, 1, 0);
    tick();
    chk_wr("full_pop1", 1, 7, 17, 32'h701);
    chk_q("full_pop1", 3, 1, 0);
    ld(0, 0, 0, 0);
    tick();
    chk_wr("full_pop2", 1, 7, 18, 32'h702);
    tick();
    chk_wr("full_pop3", 1, 7, 19, 32'h703);
    tick();
    chk_wr("full_pop4", 1, 7, 20, 32'h704);
    chk_q("full_drained", 0, 1, 0);

    // Kill: queued trd4 entry squashed, trd5 survives; same-cycle ALU trd4 dropped.
    alu(1, 0, 3, 32'hA0); ld(1, 4, 6, 32'h44);
    tick();
    chk_wr("kill_fill0", 1, 0, 3, 32'hA0);
    alu(1, 0, 3, 32'hA1); ld(1, 5, 6, 32'h55);
    tick();
    chk_q("kill_fill1", 2, 1, 0);
    alu(1, 4, 8, 32'hBB); ld(0, 0, 0, 0); kill(1, 4);
    tick();
    chk_en("kill_alu", 0);
    chk_q("kill_alu", 2, 1, 0);
    alu(0, 0, 0, 0); kill(0, 0);
    tick();
    chk_en("kill_pop_trd4", 0);
    chk_q("kill_pop_trd4", 1, 1, 0);
    tick();
    chk_wr("kill_pop_trd5", 1, 5, 6, 32'h55);
    chk_q("kill_pop_trd5", 0, 1, 0);
    alu(1, 0, 1, 32'h77);
    tick();
    chk_en("rd1_alu", 0);
    alu(1, 0, 0, 32'h78);
    tick();
    chk_en("rd0_alu", 0);
    alu(1, 2, 4, 32'h79);
    tick();
    chk_wr("rd4_alu", 1, 2, 4, 32'h79);
    alu(0, 0, 0, 0); ld(1, 2, 9, 32'h99); kill(1, 2);
    tick();
    chk_en("kill_ld_bypass", 0);
    chk_q("kill_ld_bypass", 0, 1, 0);
    ld(0, 0, 0, 0); kill(0, 0);
    tick();
    chk_en("kill_ld_nopush", 0);
    chk_q("kill_ld_nopush", 0, 1, 0);

    // Reset mid-operation with three loads queued.
    for (int k = 0; k < 3; k++) begin
      alu(1, 0, 4, 32'h300 + 32'(k));
      ld(1, 3, 5'(20 + k), 32'h800 + 32'(k));
      tick();
    end
    chk_q("pre_reset", 3, 1, 0);
    chk_wr("pre_reset", 1, 0, 4, 32'h302);
    alu(0, 0, 0, 0); ld(0, 0, 0, 0);
    #1 rst_n = 1'b0;
    #1;
    chk_wr("mid_reset", 0, 0, 0, 0);
    chk_q("mid_reset", 0, 1, 0);
    #2 rst_n = 1'b1;
    tick();
    chk_en("post_reset", 0);
    chk_q("post_reset", 0, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
